// File: rtl/field_record_pkg.sv
// Shared types and constants for the field-record stream unpacker.
package field_record_pkg;

    // Width of the length byte and of the skip counter
    localparam int LEN_BYTE_W        = 8;
    // Default payload capacity in bytes
    localparam int MAX_BYTES_DEFAULT = 8;
    localparam int LEN_W_DEFAULT     = $clog2(MAX_BYTES_DEFAULT + 1);

    // Decoder states: id byte, length byte, payload, discard, present record
    typedef enum logic [2:0] {
        S_ID   = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_SKIP = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // One decoded record at the default capacity
    typedef struct packed {
        logic [7:0]                     id;
        logic [LEN_W_DEFAULT-1:0]       len;
        logic [MAX_BYTES_DEFAULT*8-1:0] value;
    } record_t;

endpackage : field_record_pkg

// File: rtl/field_record_unpacker.sv
// Decodes a byte stream of (id, length, payload) records into one wide word per record.
// Out-of-range length bytes raise a one-cycle err pulse.
// Zero-length records are dropped.
// Over-long records have their payload skipped.
module field_record_unpacker
    import field_record_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEFAULT,
    parameter int ID_W      = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [7:0]                     in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ID_W-1:0]                out_id,
    output logic [$clog2(MAX_BYTES+1)-1:0] out_len,
    output logic [MAX_BYTES*8-1:0]         out_value,
    output logic                           err
);

    localparam int LEN_W = $clog2(MAX_BYTES + 1);
    // A single-byte payload still needs a one-bit counter
    localparam int CNT_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [LEN_BYTE_W-1:0] MAX_LEN = LEN_BYTE_W'(MAX_BYTES);

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [LEN_BYTE_W-1:0]   skip_r;

    // Record framing FSM.
    // All outputs are registered here.
    // in_ready is low only while a record is being presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_ID;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            err       <= 1'b0;
            out_id    <= '0;
            out_len   <= '0;
            out_value <= '0;
            cnt_r     <= '0;
            skip_r    <= '0;
        end else begin
            err <= 1'b0;
            case (state_r)
                S_ID: begin
                    if (in_valid) begin
                        out_id    <= in_data[ID_W-1:0];
                        out_value <= '0;
                        state_r   <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (in_valid) begin
                        if (in_data == 8'd0) begin
                            err     <= 1'b1;
                            state_r <= S_ID;
                        end else if (in_data > MAX_LEN) begin
                            err     <= 1'b1;
                            skip_r  <= in_data;
                            state_r <= S_SKIP;
                        end else begin
                            out_len <= in_data[LEN_W-1:0];
                            cnt_r   <= '0;
                            state_r <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
                        out_value[int'(cnt_r)*8 +: 8] <= in_data;
                        if (LEN_W'(cnt_r) == out_len - LEN_W'(1)) begin
                            state_r   <= S_OUT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                S_SKIP: begin
                    if (in_valid) begin
                        skip_r <= skip_r - LEN_BYTE_W'(1);
                        if (skip_r == LEN_BYTE_W'(1)) begin
                            state_r <= S_ID;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= S_ID;
                    end
                end
                default: begin
                    state_r   <= S_ID;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : field_record_unpacker

// File: tb/tb_field_record_unpacker.sv
// Directed bench for field_record_unpacker with hand-computed expectations.
`timescale 1ns / 1fs
module tb_field_record_unpacker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_id;
    logic [3:0]  out_len;
    logic [63:0] out_value;
    logic        err;

    int compared = 0;
    int mismatched = 0;

    field_record_unpacker #(.MAX_BYTES(8), .ID_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_len   (out_len),
        .out_value (out_value),
        .err       (err)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle step; sampling happens 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Inserts zero or more idle cycles before the byte
    task automatic send_gap(input logic [7:0] b);
        while ($urandom_range(1, 0) == 0) begin
            in_valid = 1'b0;
            tick();
        end
        send_byte(b);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_id", 64'(out_id), 64'd0);
        check("rst_len", 64'(out_len), 64'd0);
        check("rst_value", out_value, 64'd0);
        rst_n = 1'b1;
        tick();

        // Two-byte record with an immediately ready consumer
        send_byte(8'h05);
        send_byte(8'h02);
        send_byte(8'h34);
        check("t1_no_early_valid", 64'(out_valid), 64'd0);
        send_byte(8'h12);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_id", 64'(out_id), 64'h05);
        check("t1_len", 64'(out_len), 64'd2);
        check("t1_value", out_value, 64'h1234);
        check("t1_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        check("t1_valid_drop", 64'(out_valid), 64'd0);
        check("t1_in_ready_back", 64'(in_ready), 64'd1);

        // Full-width record held under backpressure
        out_ready = 1'b0;
        send_byte(8'h07);
        send_byte(8'h08);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        for (int c = 0; c < 5; c++) begin
            check("t2_hold_valid", 64'(out_valid), 64'd1);
            check("t2_hold_value", out_value, 64'h0807060504030201);
            check("t2_hold_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        check("t2_valid_6th", 64'(out_valid), 64'd1);
        check("t2_value_6th", out_value, 64'h0807060504030201);
        check("t2_id", 64'(out_id), 64'h07);
        check("t2_len", 64'(out_len), 64'd8);
        tick();
        check("t2_released", 64'(out_valid), 64'd0);
        check("t2_in_ready_back", 64'(in_ready), 64'd1);

        // Zero-length record raises err and is dropped
        send_byte(8'h03);
        send_byte(8'h00);
        check("t3_err_pulse", 64'(err), 64'd1);
        check("t3_no_valid", 64'(out_valid), 64'd0);
        tick();
        check("t3_err_single", 64'(err), 64'd0);
        send_byte(8'h09);
        send_byte(8'h01);
        send_byte(8'hAA);
        check("t3_valid", 64'(out_valid), 64'd1);
        check("t3_id", 64'(out_id), 64'h09);
        check("t3_len", 64'(out_len), 64'd1);
        check("t3_value", out_value, 64'hAA);
        check("t3_err_clear", 64'(err), 64'd0);
        tick();

        // Over-long record: err, ten bytes skipped, then a good record
        send_byte(8'h04);
        send_byte(8'h0A);
        check("t4_err_pulse", 64'(err), 64'd1);
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(8'hC0 + i));
            check("t4_skip_no_valid", 64'(out_valid), 64'd0);
            check("t4_skip_no_err", 64'(err), 64'd0);
        end
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h55);
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_id", 64'(out_id), 64'h02);
        check("t4_len", 64'(out_len), 64'd1);
        check("t4_value", out_value, 64'h55);
        tick();

        // Random in_valid gaps must not change the decoded result
        send_gap(8'h11);
        send_gap(8'h03);
        send_gap(8'h01);
        send_gap(8'h02);
        check("t5_no_early_valid", 64'(out_valid), 64'd0);
        send_gap(8'h03);
        check("t5_valid", 64'(out_valid), 64'd1);
        check("t5_id", 64'(out_id), 64'h11);
        check("t5_len", 64'(out_len), 64'd3);
        check("t5_value", out_value, 64'h030201);
        tick();

        // Reset in the middle of a payload discards the partial record
        send_byte(8'h06);
        send_byte(8'h04);
        send_byte(8'hFF);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_in_ready", 64'(in_ready), 64'd1);
        check("t6_rst_id", 64'(out_id), 64'd0);
        check("t6_rst_value", out_value, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_no_ghost", 64'(out_valid), 64'd0);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h7E);
        check("t6_valid", 64'(out_valid), 64'd1);
        check("t6_id", 64'(out_id), 64'h01);
        check("t6_len", 64'(out_len), 64'd1);
        check("t6_value", out_value, 64'h7E);
        tick();
        check("t6_done", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_field_record_unpacker
